// File: rtl/wash_mode_sequencer.sv
// ---------------------------------------------------------------------------
// wash_mode_sequencer
//   Top-level mode FSM for the washer. It produces the 3-bit state code that
//   drives the run/countdown controller. It selects the wash program and
//   presents that program's 26-bit phase-time word on data.
//
// Ports
//   clk          in   1   system clock, every register updates on posedge
//   rst          in   1   synchronous active-high reset
//   power_btn    in   1   power button level; a rising edge toggles on/off
//   start_btn    in   1   start/pause button level; acts on the rising edge
//   mode_btn     in   1   program-select button level; rising edge advances
//                         the program while in SET
//   door_open    in   1   door switch level, 1 = open
//   hadFinish    in   1   countdown controller: all phase fields reached 0
//   initTime     in   3   countdown controller: power-on splash counter
//   finishTime   in   3   countdown controller: end-of-cycle alarm counter
//   state        out  3   0 SHUTDOWN, 1 BEGIN, 2 SET, 3 RUN, 4 ERROR,
//                         5 PAUSE, 6 FINISH
//   prog_sel     out  2   current program index
//   data         out  26  phase-time word of the selected program
//   alarm        out  1   high while in FINISH or ERROR
// ---------------------------------------------------------------------------
module wash_mode_sequencer #(
  parameter int          NUM_PROGS = 4,
  parameter logic [25:0] PROG0     = 26'h0A4D2C9,
  parameter logic [25:0] PROG1     = 26'h0292449,
  parameter logic [25:0] PROG2     = 26'h1F7FFFF,
  parameter logic [25:0] PROG3     = 26'h0000001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        power_btn,
  input  logic        start_btn,
  input  logic        mode_btn,
  input  logic        door_open,
  input  logic        hadFinish,
  input  logic [2:0]  initTime,
  input  logic [2:0]  finishTime,
  output logic [2:0]  state,
  output logic [1:0]  prog_sel,
  output logic [25:0] data,
  output logic        alarm
);

  typedef enum logic [2:0] {
    S_SHUTDOWN = 3'd0,
    S_BEGIN    = 3'd1,
    S_SET      = 3'd2,
    S_RUN      = 3'd3,
    S_ERROR    = 3'd4,
    S_PAUSE    = 3'd5,
    S_FINISH   = 3'd6
  } state_t;

  localparam logic [1:0] PROG_MAX = 2'(NUM_PROGS - 1);

  state_t     state_q, state_d;
  logic [1:0] prog_sel_q, prog_sel_d;
  logic       err_from_set_q, err_from_set_d;

  // Button history: loaded with 1 in reset so a button held through reset
  // does not register as a press once reset is released.
  logic power_q, start_q, mode_q;

  logic power_edge, start_edge, mode_edge;

  assign power_edge = power_btn & ~power_q;
  assign start_edge = start_btn & ~start_q;
  assign mode_edge  = mode_btn  & ~mode_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_SHUTDOWN;
      prog_sel_q     <= 2'd0;
      err_from_set_q <= 1'b0;
      power_q        <= 1'b1;
      start_q        <= 1'b1;
      mode_q         <= 1'b1;
    end else begin
      state_q        <= state_d;
      prog_sel_q     <= prog_sel_d;
      err_from_set_q <= err_from_set_d;
      power_q        <= power_btn;
      start_q        <= start_btn;
      mode_q         <= mode_btn;
    end
  end

  always_comb begin
    state_d        = state_q;
    prog_sel_d     = prog_sel_q;
    err_from_set_d = err_from_set_q;

    if (power_edge) begin
      // Power overrides everything else in the cycle it is seen.
      if (state_q == S_SHUTDOWN) begin
        state_d = S_BEGIN;
      end else begin
        state_d    = S_SHUTDOWN;
        prog_sel_d = 2'd0;
      end
    end else begin
      unique case (state_q)
        S_SHUTDOWN: ;
        S_BEGIN: begin
          if (initTime == 3'd0) state_d = S_BEGIN == S_BEGIN ? S_SET : S_BEGIN;
        end
        S_SET: begin
          // A start press takes precedence over a simultaneous mode press.
          if (start_edge) begin
            if (door_open) begin
              state_d        = S_ERROR;
              err_from_set_d = 1'b1;
            end else begin
              state_d = S_RUN;
            end
          end else if (mode_edge) begin
            prog_sel_d = (prog_sel_q >= PROG_MAX) ? 2'd0 : prog_sel_q + 2'd1;
          end
        end
        S_RUN: begin
          if (door_open) begin
            state_d        = S_ERROR;
            err_from_set_d = 1'b0;
          end else if (hadFinish) begin
            state_d = S_FINISH;
          end else if (start_edge) begin
            state_d = S_PAUSE;
          end
        end
        S_PAUSE: begin
          // An open door only matters once the user tries to resume.
          if (start_edge) begin
            if (door_open) begin
              state_d        = S_ERROR;
              err_from_set_d = 1'b0;
            end else begin
              state_d = S_RUN;
            end
          end
        end
        S_ERROR: begin
          if (!door_open) state_d = err_from_set_q ? S_SET : S_PAUSE;
        end
        S_FINISH: begin
          if (finishTime == 3'd0) begin
            state_d    = S_SHUTDOWN;
            prog_sel_d = 2'd0;
          end
        end
        default: state_d = S_SHUTDOWN;
      endcase
    end
  end

  always_comb begin
    data = PROG0;
    case (prog_sel_q)
      2'd0:    data = PROG0;
      2'd1:    data = PROG1;
      2'd2:    data = PROG2;
      default: data = PROG3;
    endcase
  end

  assign state    = state_q;
  assign prog_sel = prog_sel_q;
  assign alarm    = (state_q == S_FINISH) || (state_q == S_ERROR);

endmodule

// File: tb/tb_wash_mode_sequencer.sv
`timescale 1ns/1ps
module tb_wash_mode_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        power_btn, start_btn, mode_btn, door_open, hadFinish;
  logic [2:0]  initTime, finishTime;
  logic [2:0]  state;
  logic [1:0]  prog_sel;
  logic [25:0] data;
  logic        alarm;

  int checks = 0;
  int errors = 0;

  logic [25:0] progs [4] = '{26'h0A4D2C9, 26'h0292449, 26'h1F7FFFF, 26'h0000001};

  // Reference model: state codes as plain integers, program as an int mod 4.
  int m_state, m_prog;
  bit m_err_set;
  bit h_pw, h_st, h_md;

  always #5 clk = ~clk;

  wash_mode_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .power_btn  (power_btn),
    .start_btn  (start_btn),
    .mode_btn   (mode_btn),
    .door_open  (door_open),
    .hadFinish  (hadFinish),
    .initTime   (initTime),
    .finishTime (finishTime),
    .state      (state),
    .prog_sel   (prog_sel),
    .data       (data),
    .alarm      (alarm)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge of the behavioural reference, using the inputs present at the edge.
  task automatic model_edge();
    bit pwr, st, md;
    if (rst) begin
      m_state = 0; m_prog = 0; m_err_set = 0;
      h_pw = 1; h_st = 1; h_md = 1;
      return;
    end
    pwr = power_btn && !h_pw;
    st  = start_btn && !h_st;
    md  = mode_btn  && !h_md;
    h_pw = power_btn; h_st = start_btn; h_md = mode_btn;
    if (pwr) begin
      if (m_state == 0) m_state = 1;
      else begin m_state = 0; m_prog = 0; end
      return;
    end
    if (m_state == 1 && initTime == 0) m_state = 2;
    else if (m_state == 2 && st) begin
      m_err_set = door_open;
      m_state   = door_open ? 4 : 3;
    end
    else if (m_state == 2 && md) m_prog = (m_prog + 1) % 4;
    else if (m_state == 3 && door_open) begin m_state = 4; m_err_set = 0; end
    else if (m_state == 3 && hadFinish) m_state = 6;
    else if (m_state == 3 && st) m_state = 5;
    else if (m_state == 5 && st) begin
      if (door_open) begin m_state = 4; m_err_set = 0; end
      else m_state = 3;
    end
    else if (m_state == 4 && !door_open) m_state = m_err_set ? 2 : 5;
    else if (m_state == 6 && finishTime == 0) begin m_state = 0; m_prog = 0; end
  endtask

  // One transaction: clock edge, model update, compare all outputs.
  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, ".state"}, 32'(state), 32'(m_state));
    check({tag, ".prog"},  32'(prog_sel), 32'(m_prog));
    check({tag, ".data"},  32'(data), 32'(progs[m_prog]));
    check({tag, ".alarm"}, 32'(alarm), 32'((m_state == 4 || m_state == 6) ? 1 : 0));
    $display("[%0t] %s rst=%0b pw=%0b st=%0b md=%0b door=%0b hf=%0b it=%0d ft=%0d -> state=%0d prog=%0d alarm=%0b",
             $time, tag, rst, power_btn, start_btn, mode_btn, door_open, hadFinish,
             initTime, finishTime, state, prog_sel, alarm);
  endtask

  task automatic press_start(input string tag);
    start_btn = 1'b1; cyc(tag);
    start_btn = 1'b0; cyc({tag, "_rel"});
  endtask

  task automatic press_mode(input string tag);
    mode_btn = 1'b1; cyc(tag);
    mode_btn = 1'b0; cyc({tag, "_rel"});
  endtask

  task automatic press_power(input string tag);
    power_btn = 1'b1; cyc(tag);
    power_btn = 1'b0; cyc({tag, "_rel"});
  endtask

  initial begin
    rst = 1'b1; power_btn = 0; start_btn = 0; mode_btn = 0; door_open = 0;
    hadFinish = 0; initTime = 3'd5; finishTime = 3'd3;

    // T1: reset, power on, splash countdown
    cyc("T1_rst0"); cyc("T1_rst1");
    check("T1_reset_state", 32'(state), 32'd0);
    check("T1_reset_data", 32'(data), 32'h0A4D2C9);
    rst = 1'b0;
    cyc("T1_idle");
    power_btn = 1'b1; cyc("T1_pwr");
    check("T1_begin", 32'(state), 32'd1);
    power_btn = 1'b0;
    for (int t = 4; t >= 0; t--) begin
      initTime = 3'(t);
      cyc("T1_init");
      check("T1_begin_hold", 32'(state), (t == 0) ? 32'd2 : 32'd1);
    end

    // T2: program selection with wrap, then start
    begin
      int exp_p [5] = '{1, 2, 3, 0, 1};
      for (int i = 0; i < 5; i++) begin
        mode_btn = 1'b1; cyc("T2_mode");
        check("T2_prog", 32'(prog_sel), 32'(exp_p[i]));
        mode_btn = 1'b0; cyc("T2_mode_rel");
      end
    end
    check("T2_data", 32'(data), 32'h0292449);
    press_start("T2_start");
    check("T2_run", 32'(state), 32'd3);

    // T3: door opens together with start in RUN
    door_open = 1'b1; start_btn = 1'b1; cyc("T3_door_start");
    check("T3_error", 32'(state), 32'd4);
    check("T3_alarm", 32'(alarm), 32'd1);
    start_btn = 1'b0; door_open = 1'b0; cyc("T3_close");
    check("T3_pause", 32'(state), 32'd5);
    press_start("T3_resume");
    check("T3_run", 32'(state), 32'd3);

    // T5: hadFinish beats start; alarm countdown ends in SHUTDOWN
    finishTime = 3'd2;
    hadFinish = 1'b1; start_btn = 1'b1; cyc("T5_finish");
    check("T5_finish_state", 32'(state), 32'd6);
    check("T5_alarm", 32'(alarm), 32'd1);
    hadFinish = 1'b0; start_btn = 1'b0;
    mode_btn = 1'b1; cyc("T5_mode_ignored");
    mode_btn = 1'b0;
    finishTime = 3'd1; cyc("T5_ft1");
    finishTime = 3'd0; cyc("T5_ft0");
    check("T5_shutdown", 32'(state), 32'd0);
    check("T5_prog_clear", 32'(prog_sel), 32'd0);

    // T4: start with the door open from SET, then close the door
    initTime = 3'd0;
    press_power("T4_pwr");
    press_mode("T4_mode");
    door_open = 1'b1;
    press_start("T4_start");
    check("T4_error", 32'(state), 32'd4);
    door_open = 1'b0; cyc("T4_close");
    check("T4_back_set", 32'(state), 32'd2);
    check("T4_prog_kept", 32'(prog_sel), 32'd1);

    // Power-off from SET clears the program
    press_power("T4_off");
    check("T4_off_state", 32'(state), 32'd0);

    // T6: power held through reset, then reset mid-PAUSE
    power_btn = 1'b1; rst = 1'b1; cyc("T6_rst");
    rst = 1'b0; cyc("T6_held");
    check("T6_no_edge", 32'(state), 32'd0);
    power_btn = 1'b0; cyc("T6_rel");
    press_power("T6_pwr");
    press_mode("T6_mode");
    press_start("T6_run");
    press_start("T6_pause");
    check("T6_pause_state", 32'(state), 32'd5);
    rst = 1'b1; cyc("T6_rst_pause");
    check("T6_rst_state", 32'(state), 32'd0);
    check("T6_rst_prog", 32'(prog_sel), 32'd0);
    rst = 1'b0;

    // Randomized phase against the reference model
    for (int n = 0; n < 1500; n++) begin
      rst        = ($urandom_range(0, 99) < 1);
      power_btn  = ($urandom_range(0, 99) < 6);
      start_btn  = ($urandom_range(0, 99) < 35);
      mode_btn   = ($urandom_range(0, 99) < 35);
      if ($urandom_range(0, 99) < 15) door_open = ~door_open;
      hadFinish  = ($urandom_range(0, 99) < 10);
      initTime   = 3'($urandom_range(0, 2));
      finishTime = 3'($urandom_range(0, 2));
      cyc("RND");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
